// File: rtl/mem_split.sv
`default_nettype none
// ============================================================================
// Module   : mem_split
// Purpose  : Splits a byte transfer request into bus cycles that never cross
//            a port-width boundary, with byte-lane enables per cycle.
// Revision : 1.0  initial release
// ============================================================================
module mem_split #(
  parameter  int BUS_BYTES = 8,
  parameter  int AW        = 24,
  parameter  int LW        = 5,
  localparam int MWW       = (BUS_BYTES == 16) ? 3 : 2
) (
  input  logic                 sys_clk,
  input  logic                 resetl,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AW-1:0]        req_addr,
  input  logic [LW-1:0]        req_len,
  input  logic [MWW-1:0]       req_mw,
  input  logic                 req_bigend,
  input  logic                 abort,
  output logic                 cyc_valid,
  input  logic                 cyc_ready,
  output logic [AW-1:0]        cyc_addr,
  output logic [BUS_BYTES-1:0] cyc_bm,
  output logic [LW-1:0]        cyc_nbytes,
  output logic                 cyc_last,
  output logic                 done
);

  localparam int LOG2B = (BUS_BYTES == 16) ? 4 : 3;
  localparam int CW    = (LW > 5) ? LW : 5;
  localparam int BW    = CW + 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SPLIT = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_cur_addr, w_addr_nxt;
  logic [LW-1:0]   r_remain, w_remain_nxt;
  logic [MWW-1:0]  r_mw, w_mw_nxt, w_mw_clamped;
  logic            r_bigend, w_bigend_nxt;
  logic            r_done, w_done_nxt;

  logic                 w_split, w_hs, w_acc, w_last;
  logic [4:0]           w_pbytes, w_offs, w_room;
  logic [LW-1:0]        w_nbytes;
  logic [LOG2B-1:0]     w_lane;
  logic [BW-1:0]        w_lo, w_hi;
  logic [BUS_BYTES-1:0] w_bm_le, w_bm;

  // Bytes left before the next port-width boundary.
  assign w_pbytes = 5'd1 << r_mw;
  assign w_offs   = r_cur_addr[4:0] & (w_pbytes - 5'd1);
  assign w_room   = w_pbytes - w_offs;
  assign w_nbytes = (CW'(w_room) < CW'(r_remain)) ? LW'(w_room) : r_remain;
  assign w_last   = (w_nbytes == r_remain);

  assign w_lane = r_cur_addr[LOG2B-1:0];
  assign w_lo   = BW'(w_lane);
  assign w_hi   = w_lo + BW'(w_nbytes);

  always_comb begin
    w_bm_le = '0;
    w_bm    = '0;
    for (int i = 0; i < BUS_BYTES; i++) begin
      w_bm_le[i] = (BW'(i) >= w_lo) && (BW'(i) < w_hi);
    end
    for (int i = 0; i < BUS_BYTES; i++) begin
      w_bm[i] = r_bigend ? w_bm_le[BUS_BYTES-1-i] : w_bm_le[i];
    end
  end

  assign w_split    = (r_state == S_SPLIT);
  assign cyc_valid  = w_split;
  assign cyc_addr   = w_split ? r_cur_addr : '0;
  assign cyc_bm     = w_split ? w_bm : '0;
  assign cyc_nbytes = w_split ? w_nbytes : '0;
  assign cyc_last   = w_split & w_last;
  assign done       = r_done;

  assign w_hs      = cyc_valid & cyc_ready;
  assign req_ready = ~w_split | (w_hs & w_last & ~abort);
  assign w_acc     = req_valid & req_ready;

  assign w_mw_clamped = (req_mw > MWW'(LOG2B)) ? MWW'(LOG2B) : req_mw;

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_cur_addr;
    w_remain_nxt = r_remain;
    w_mw_nxt     = r_mw;
    w_bigend_nxt = r_bigend;
    w_done_nxt   = 1'b0;
    if (w_split && abort) begin
      w_state_nxt = S_IDLE;
      w_done_nxt  = 1'b1;
    end else if (w_split && w_hs && !w_last) begin
      w_addr_nxt   = r_cur_addr + AW'(w_nbytes);
      w_remain_nxt = r_remain - w_nbytes;
    end else if (!w_split || w_hs) begin
      // Idle, or the final handshake: possibly reload in the same cycle.
      if (w_split) begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      if (w_acc) begin
        if (req_len != '0) begin
          w_state_nxt  = S_SPLIT;
          w_addr_nxt   = req_addr;
          w_remain_nxt = req_len;
          w_mw_nxt     = w_mw_clamped;
          w_bigend_nxt = req_bigend;
        end else begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_state    <= S_IDLE;
      r_cur_addr <= '0;
      r_remain   <= '0;
      r_mw       <= '0;
      r_bigend   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_addr <= w_addr_nxt;
      r_remain   <= w_remain_nxt;
      r_mw       <= w_mw_nxt;
      r_bigend   <= w_bigend_nxt;
      r_done     <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire
